vc_pop_arbiter: RTL and testbench
=================================

Name: vc_pop_arbiter

Overview:
- Downstream consumer of the four per-channel 12-bit FIFOs in the transaction layer.
- Pops one word per cycle at most, choosing among non-empty channels in round-robin order.
- Captures the popped word and pushes it into a single shared output FIFO.
- Honours output almost_full backpressure and guards against the upstream empty flag, which lags by one cycle because it is registered.

Parameters:
- NUM_CH, 4, number of upstream channel FIFOs; RTL is required to support 4 only.
- DATA_W, 12, word width.
- GUARD_CYC, 2, cycles a channel stays ineligible after being popped.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  when 0, no new pops are issued; in-flight words still complete.
- ch_empty  in  NUM_CH  almost_empty flag of each upstream FIFO (bit k = channel k).
- ch_data  in  NUM_CH*DATA_W  upstream data_out buses; channel k occupies bits [k*12+11:k*12].
- pop  out  NUM_CH  registered, one-hot-or-zero pop strobe to upstream FIFOs.
- out_almost_full  in  1  almost_full flag of the output FIFO.
- push_out  out  1  registered push strobe to the output FIFO.
- data_out  out  DATA_W  word accompanying push_out.
- last_grant  out  2  channel of the most recent pop.
- word_count  out  8  total words pushed; wraps 255 -> 0.

Behaviour:
- Reset (reset==0 at posedge): pop=0, push_out=0, data_out=0, last_grant=3 (so channel 0 has first priority), word_count=0. All guard counters and pipeline valid bits clear; any in-flight words are dropped.
- Eligibility of channel k: ch_empty[k]==0 and guard[k]==0.
- Issue condition: enable==1, out_almost_full==0, and at least one channel eligible.
- Search order: last_grant+1, +2, +3, +4, mod 4.
- Grant: the first eligible channel in search order is selected combinationally and registered, so pop[k]=1 for exactly one cycle (call it N). At that same edge last_grant<=k and guard[k]<=GUARD_CYC.
- Guard counters decrement once per cycle while nonzero.
- Single-channel throughput: bounded to one pop per 3 cycles.
- Multi-channel throughput: one pop per cycle.
- Data latency:
  - Upstream presents the popped word on ch_data during cycle N+1.
  - The block registers data_out<=ch_data[k] and push_out<=1 at the end of N+1.
  - push_out is therefore high during cycle N+2, for one cycle per word.
  - pop-to-push latency is fixed at 2 cycles.
- Pipeline: a 2-entry shift of {valid, channel}. Back-to-back pops produce back-to-back pushes, in pop order.
- Backpressure:
  - out_almost_full==1 only blocks new pops.
  - Words already popped are always pushed, up to 2 in flight.
  - The output FIFO's ALMOST_FULL must be ≤ depth-2; this is a system requirement, not checked here.
- enable deassert: same as backpressure; the pipeline drains.
- data_out holds its last value when push_out==0.
- word_count increments on every cycle with push_out==1; 8-bit wrap.
- No channel is ever popped while ch_empty[k]==1 at the issue edge.
- Simultaneous events:
  - A reset edge overrides everything.
  - An eligibility change and a grant on the same edge use the pre-edge values.

Decomposition:
- Shared package/header holds NUM_CH, DATA_W, GUARD_CYC, and the channel-index width (2).
- One sub-module, rr_pick: combinational rotate-priority picker.
  - Inputs: eligible[3:0], last_grant[1:0].
  - Outputs: grant_onehot[3:0], grant_idx[1:0], any.
- The top level holds the guard counters, pipeline, and counters.

Test Plan:
- Reset, then ch_empty=4'b1110, ch0 word 0x0A5, out_almost_full=0 → pop=0001 at N, push_out at N+2 with data_out=0x0A5, word_count=1; next pop of ch0 no earlier than N+3.
- All channels non-empty with distinct words 0x100/0x201/0x302/0x403 → pop sequence ch0,ch1,ch2,ch3,ch0 on consecutive cycles; pushes in the same order 2 cycles later.
- Stream running, out_almost_full raised at cycle M → no pop from M onward; at most 2 further pushes; pops resume one cycle after the flag drops.
- ch_empty=4'b1111, enable=1 → pop and push_out stay 0 indefinitely; word_count unchanged.
- reset asserted the cycle after a pop → push_out stays 0, data_out=0, last_grant=3; after release, channel 0 is granted first.
- 256 pushes → word_count returns to 0 with no glitch on push_out.

Source files
------------

// File: rtl/vc_pop_arbiter_pkg.sv
// rtl/vc_pop_arbiter_pkg.sv - shared parameters, types and helpers for the channel pop arbiter
package vc_pop_arbiter_pkg;

  localparam int NUM_CH    = 4;
  localparam int DATA_W    = 12;
  localparam int GUARD_CYC = 2;
  localparam int CH_W      = 2;
  localparam int GUARD_W   = 2;
  localparam int CNT_W     = 8;

  // One slot of the pop-to-push pipeline: which channel's word is in flight.
  typedef struct packed {
    logic            valid;
    logic [CH_W-1:0] ch;
  } pipe_t;

  // Extract channel idx's word from the concatenated upstream data buses.
  function automatic logic [DATA_W-1:0] ch_word(
    input logic [NUM_CH*DATA_W-1:0] bus,
    input logic [CH_W-1:0]          idx
  );
    return bus[idx*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/vc_pop_arbiter_if.sv
// rtl/vc_pop_arbiter_if.sv - upstream FIFO and output FIFO handshake bundle
interface vc_pop_arbiter_if;
  import vc_pop_arbiter_pkg::*;

  logic [NUM_CH-1:0]        ch_empty;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        pop;
  logic                     out_almost_full;
  logic                     push_out;
  logic [DATA_W-1:0]        data_out;

  // Arbiter side: pops the channel FIFOs and pushes the output FIFO.
  modport master (
    input  ch_empty, ch_data, out_almost_full,
    output pop, push_out, data_out
  );

  // FIFO side: supplies flags and data, receives strobes.
  modport slave (
    output ch_empty, ch_data, out_almost_full,
    input  pop, push_out, data_out
  );

endinterface

// File: rtl/vc_pop_arbiter_rr_pick.sv
// rtl/vc_pop_arbiter_rr_pick.sv - combinational rotate-priority picker starting after last grant
module vc_pop_arbiter_rr_pick
  import vc_pop_arbiter_pkg::*;
(
  input  logic [NUM_CH-1:0] eligible_i,
  input  logic [CH_W-1:0]   last_grant_i,
  output logic [NUM_CH-1:0] grant_onehot_o,
  output logic [CH_W-1:0]   grant_idx_o,
  output logic              any_o
);

  logic            found;
  logic [CH_W-1:0] cand;
  logic [CH_W-1:0] pick;

  // Walk last_grant+1 .. last_grant+4 (mod 4) and take the first eligible channel.
  always_comb begin
    found = 1'b0;
    cand  = '0;
    pick  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = last_grant_i + CH_W'(i);
      if (!found && eligible_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    grant_onehot_o       = '0;
    grant_onehot_o[pick] = found;
    grant_idx_o          = pick;
    any_o                = found;
  end

endmodule

// File: rtl/vc_pop_arbiter.sv
// rtl/vc_pop_arbiter.sv - round-robin popper of four channel FIFOs into one output FIFO
module vc_pop_arbiter
  import vc_pop_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_i,
  vc_pop_arbiter_if.master  bus,
  output logic [CH_W-1:0]   last_grant_o,
  output logic [CNT_W-1:0]  word_count_o
);

  logic [NUM_CH-1:0]  eligible;
  logic [NUM_CH-1:0]  grant_onehot;
  logic [CH_W-1:0]    grant_idx;
  logic               any_elig;
  logic               issue;

  logic [GUARD_W-1:0] guard_q [NUM_CH];
  logic [GUARD_W-1:0] guard_d [NUM_CH];
  pipe_t              stage0_q;
  pipe_t              stage1_q;
  logic [NUM_CH-1:0]  pop_q;
  logic               push_q;
  logic [DATA_W-1:0]  data_q;
  logic [CH_W-1:0]    last_grant_q;
  logic [CNT_W-1:0]   word_count_q;

  // A channel is poppable only when its FIFO reports data and its post-pop guard has expired;
  // the guard hides the one-cycle lag of the registered upstream empty flag.
  always_comb begin
    eligible = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      eligible[k] = !bus.ch_empty[k] && (guard_q[k] == '0);
    end
    issue = enable_i && !bus.out_almost_full && any_elig;
  end

  vc_pop_arbiter_rr_pick u_pick (
    .eligible_i     (eligible),
    .last_grant_i   (last_grant_q),
    .grant_onehot_o (grant_onehot),
    .grant_idx_o    (grant_idx),
    .any_o          (any_elig)
  );

  // Reload the granted channel's guard, count every other nonzero guard down.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      guard_d[k] = guard_q[k];
      if (issue && grant_onehot[k]) begin
        guard_d[k] = GUARD_W'(GUARD_CYC);
      end else if (guard_q[k] != '0) begin
        guard_d[k] = guard_q[k] - 1'b1;
      end
    end
  end

  // Pop strobe, two-stage in-flight tracking, output capture and word counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pop_q        <= '0;
      push_q       <= 1'b0;
      data_q       <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
      word_count_q <= '0;
      stage0_q     <= '0;
      stage1_q     <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        guard_q[k] <= '0;
      end
    end else begin
      pop_q <= issue ? grant_onehot : '0;
      if (issue) begin
        last_grant_q <= grant_idx;
      end
      stage0_q.valid <= issue;
      stage0_q.ch    <= grant_idx;
      stage1_q       <= stage0_q;
      push_q         <= stage1_q.valid;
      if (stage1_q.valid) begin
        data_q <= ch_word(bus.ch_data, stage1_q.ch);
      end
      word_count_q <= word_count_q + {{(CNT_W-1){1'b0}}, push_q};
      for (int k = 0; k < NUM_CH; k++) begin
        guard_q[k] <= guard_d[k];
      end
    end
  end

  assign bus.pop       = pop_q;
  assign bus.push_out  = push_q;
  assign bus.data_out  = data_q;
  assign last_grant_o  = last_grant_q;
  assign word_count_o  = word_count_q;

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// tb/tb_vc_pop_arbiter.sv - directed checks of the round-robin channel pop arbiter
module tb_vc_pop_arbiter;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [1:0] last_grant;
  logic [7:0] word_count;

  int n_cmp = 0;
  int n_bad = 0;

  vc_pop_arbiter_if bus ();

  vc_pop_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .enable_i     (enable),
    .bus          (bus),
    .last_grant_o (last_grant),
    .word_count_o (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic [3:0]  empty;
    logic        afull;
    logic [3:0]  pop;
    logic        push;
    logic [11:0] data;
    logic [1:0]  lg;
    logic [7:0]  wc;
  } vec_t;

  vec_t vecs [26];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    int pushes;
    int gaps;
    bit done;

    // rst, en, empty, afull | pop, push, data, last_grant, word_count
    vecs[0]  = '{1'b0, 1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 12'h000, 2'd3, 8'd0};
    vecs[1]  = '{1'b1, 1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 12'h000, 2'd3, 8'd0};
    vecs[2]  = '{1'b1, 1'b1, 4'h0, 1'b0, 4'h1, 1'b0, 12'h000, 2'd0, 8'd0};
    vecs[3]  = '{1'b1, 1'b1, 4'h0, 1'b0, 4'h2, 1'b0, 12'h000, 2'd1, 8'd0};
    vecs[4]  = '{1'b1, 1'b1, 4'h0, 1'b0, 4'h4, 1'b1, 12'h100, 2'd2, 8'd0};
    vecs[5]  = '{1'b1, 1'b1, 4'h0, 1'b0, 4'h8, 1'b1, 12'h201, 2'd3, 8'd1};
    vecs[6]  = '{1'b1, 1'b1, 4'h0, 1'b0, 4'h1, 1'b1, 12'h302, 2'd0, 8'd2};
    vecs[7]  = '{1'b1, 1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 12'h403, 2'd0, 8'd3};
    vecs[8]  = '{1'b1, 1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 12'h100, 2'd0, 8'd4};
    vecs[9]  = '{1'b1, 1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 12'h100, 2'd0, 8'd5};
    vecs[10] = '{1'b1, 1'b1, 4'h0, 1'b0, 4'h2, 1'b0, 12'h100, 2'd1, 8'd5};
    vecs[11] = '{1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 12'h100, 2'd1, 8'd5};
    vecs[12] = '{1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 12'h201, 2'd1, 8'd5};
    vecs[13] = '{1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 12'h201, 2'd1, 8'd6};
    vecs[14] = '{1'b1, 1'b1, 4'hD, 1'b0, 4'h2, 1'b0, 12'h201, 2'd1, 8'd6};
    vecs[15] = '{1'b1, 1'b1, 4'hD, 1'b0, 4'h0, 1'b0, 12'h201, 2'd1, 8'd6};
    vecs[16] = '{1'b1, 1'b1, 4'hD, 1'b0, 4'h0, 1'b1, 12'h201, 2'd1, 8'd6};
    vecs[17] = '{1'b1, 1'b1, 4'hD, 1'b0, 4'h2, 1'b0, 12'h201, 2'd1, 8'd7};
    vecs[18] = '{1'b1, 1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 12'h201, 2'd1, 8'd7};
    vecs[19] = '{1'b1, 1'b1, 4'hF, 1'b0, 4'h0, 1'b1, 12'h201, 2'd1, 8'd7};
    vecs[20] = '{1'b1, 1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 12'h201, 2'd1, 8'd8};
    vecs[21] = '{1'b1, 1'b1, 4'h0, 1'b0, 4'h4, 1'b0, 12'h201, 2'd2, 8'd8};
    vecs[22] = '{1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 12'h000, 2'd3, 8'd0};
    vecs[23] = '{1'b1, 1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 12'h000, 2'd3, 8'd0};
    vecs[24] = '{1'b1, 1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 12'h000, 2'd3, 8'd0};
    vecs[25] = '{1'b1, 1'b1, 4'h0, 1'b0, 4'h1, 1'b0, 12'h000, 2'd0, 8'd0};

    // Single channel: ch0 only, word 0x0A5.
    reset               = 1'b0;
    enable              = 1'b1;
    bus.ch_empty        = 4'hF;
    bus.ch_data         = {12'h403, 12'h302, 12'h201, 12'h0A5};
    bus.out_almost_full = 1'b0;
    tick();
    chk("rst pop", 32'(bus.pop), 32'h0);
    chk("rst push", 32'(bus.push_out), 32'h0);
    chk("rst data", 32'(bus.data_out), 32'h0);
    chk("rst last_grant", 32'(last_grant), 32'd3);
    chk("rst word_count", 32'(word_count), 32'd0);
    reset        = 1'b1;
    bus.ch_empty = 4'b1110;
    tick();
    chk("single N pop", 32'(bus.pop), 32'h1);
    tick();
    chk("single N+1 pop", 32'(bus.pop), 32'h0);
    chk("single N+1 push", 32'(bus.push_out), 32'h0);
    tick();
    chk("single N+2 pop", 32'(bus.pop), 32'h0);
    chk("single N+2 push", 32'(bus.push_out), 32'h1);
    chk("single N+2 data", 32'(bus.data_out), 32'h0A5);
    tick();
    chk("single N+3 pop", 32'(bus.pop), 32'h1);
    chk("single N+3 push", 32'(bus.push_out), 32'h0);
    chk("single N+3 word_count", 32'(word_count), 32'd1);
    chk("single N+3 data hold", 32'(bus.data_out), 32'h0A5);

    // Table: rotation, backpressure, enable drain, guard spacing, reset mid-flight.
    bus.ch_data = {12'h403, 12'h302, 12'h201, 12'h100};
    for (int i = 0; i < 26; i++) begin
      reset               = vecs[i].rst_n;
      enable              = vecs[i].en;
      bus.ch_empty        = vecs[i].empty;
      bus.out_almost_full = vecs[i].afull;
      tick();
      chk($sformatf("v%0d pop", i), 32'(bus.pop), 32'(vecs[i].pop));
      chk($sformatf("v%0d push", i), 32'(bus.push_out), 32'(vecs[i].push));
      chk($sformatf("v%0d data", i), 32'(bus.data_out), 32'(vecs[i].data));
      chk($sformatf("v%0d last_grant", i), 32'(last_grant), 32'(vecs[i].lg));
      chk($sformatf("v%0d word_count", i), 32'(word_count), 32'(vecs[i].wc));
    end

    // Counter wrap: 256 back-to-back pushes.
    reset        = 1'b0;
    bus.ch_empty = 4'hF;
    tick();
    reset        = 1'b1;
    bus.ch_empty = 4'h0;
    pushes = 0;
    gaps   = 0;
    done   = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      tick();
      if (bus.push_out) begin
        pushes++;
        if (pushes == 256) begin
          chk("wrap count at 256th push", 32'(word_count), 32'd255);
          tick();
          chk("wrap count after 256th push", 32'(word_count), 32'd0);
          chk("wrap push continues", 32'(bus.push_out), 32'h1);
          done = 1'b1;
        end
      end else if (pushes > 0) begin
        gaps++;
      end
    end
    chk("wrap pushes reached", 32'(pushes), 32'd256);
    chk("wrap push gaps", 32'(gaps), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
